// File: rtl/cred_enroller.sv
// cred_enroller
// Enrollment side of the login path. It accepts a username/password pair and
// rejects it if either string is empty, if the username already exists, or if
// the table is full. Otherwise it hashes the password one byte per cycle with
// FNV-1a 32, then writes the username to the CAM and the hash to the hash RAM
// at the lowest free slot.
//
// Ports
//   clk, reset            single clock; synchronous active-high reset
//   start                 enroll request, sampled only while idle
//   username, password    8-byte strings, byte0 = [7:0], terminated by 0x00
//   busy, done            busy in every non-idle state; done is a 1-cycle pulse
//   status, slot          result: 0 OK, 1 DUPLICATE, 2 FULL, 3 BAD_INPUT; slot
//                         written on OK. Both hold until the next request is
//                         evaluated.
//   cam_query, cam_hit    lookup of the latched username (cam_hit comes back
//                         combinationally)
//   cam_we/waddr/wdata/wlen   CAM write port
//   hash_we/waddr/wdata       hash RAM write port (same cycle and slot as CAM)
module cred_enroller #(
    parameter int NUM_SLOTS = 8,
    parameter int ADDR_W    = 3,
    parameter int HASH_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [63:0]       username,
    input  logic [63:0]       password,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [ADDR_W-1:0] slot,
    output logic [63:0]       cam_query,
    input  logic              cam_hit,
    output logic              cam_we,
    output logic [ADDR_W-1:0] cam_waddr,
    output logic [63:0]       cam_wdata,
    output logic [3:0]        cam_wlen,
    output logic              hash_we,
    output logic [ADDR_W-1:0] hash_waddr,
    output logic [HASH_W-1:0] hash_wdata
);

    localparam logic [HASH_W-1:0] FNV_INIT  = HASH_W'(32'h811C9DC5);
    localparam logic [HASH_W-1:0] FNV_PRIME = HASH_W'(32'h01000193);

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_DUP = 2'd1;
    localparam logic [1:0] ST_FUL = 2'd2;
    localparam logic [1:0] ST_BAD = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_HASH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [63:0]          user_q;
    logic [63:0]          pw_q;
    logic [NUM_SLOTS-1:0] occ;
    logic [3:0]           idx;
    logic [HASH_W-1:0]    h;
    logic [1:0]           status_q;
    logic [ADDR_W-1:0]    slot_q;

    // Number of non-zero bytes before the first 0x00.
    function automatic logic [3:0] str_len(input logic [63:0] s);
        logic stop;
        str_len = 4'd0;
        stop    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!stop && s[8*i +: 8] != 8'h00) str_len = str_len + 4'd1;
            else                               stop    = 1'b1;
        end
    endfunction

    // Zero every byte from the terminator onward so the stored username and
    // the CAM query never carry garbage bytes from past the string end.
    function automatic logic [63:0] trim(input logic [63:0] s);
        logic [3:0] n;
        n    = str_len(s);
        trim = '0;
        for (int i = 0; i < 8; i++)
            if (4'(i) < n) trim[8*i +: 8] = s[8*i +: 8];
    endfunction

    logic [3:0]        user_len, pw_len;
    logic              bad_input, table_full, free_found;
    logic [ADDR_W-1:0] free_idx;
    logic [7:0]        pw_byte;
    logic [HASH_W-1:0] h_next;

    assign user_len   = str_len(user_q);
    assign pw_len     = str_len(pw_q);
    assign bad_input  = (user_len == 4'd0) || (pw_len == 4'd0);
    assign table_full = &occ;
    assign pw_byte    = pw_q[{idx[2:0], 3'b000} +: 8];
    assign h_next     = (h ^ HASH_W'(pw_byte)) * FNV_PRIME;

    // Lowest-index free slot: scan downward so the last assignment wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occ[i]) begin
                free_found = 1'b1;
                free_idx   = ADDR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b1;
        done    = 1'b0;
        cam_we  = 1'b0;
        hash_we = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_n = S_CHECK;
            end
            S_CHECK: begin
                if (bad_input || cam_hit || table_full || !free_found) state_n = S_DONE;
                else                                                   state_n = S_HASH;
            end
            S_HASH: begin
                if (idx == pw_len - 4'd1) state_n = S_WRITE;
            end
            S_WRITE: begin
                cam_we  = 1'b1;
                hash_we = 1'b1;
                state_n = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            user_q   <= '0;
            pw_q     <= '0;
            occ      <= '0;
            idx      <= '0;
            h        <= FNV_INIT;
            status_q <= ST_OK;
            slot_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        user_q <= trim(username);
                        pw_q   <= password;
                    end
                end
                S_CHECK: begin
                    idx <= '0;
                    h   <= FNV_INIT;
                    if (bad_input)       status_q <= ST_BAD;
                    else if (cam_hit)    status_q <= ST_DUP;
                    else if (table_full) status_q <= ST_FUL;
                    else begin
                        status_q <= ST_OK;
                        slot_q   <= free_idx;
                    end
                end
                S_HASH: begin
                    h   <= h_next;
                    idx <= idx + 4'd1;
                end
                S_WRITE: occ[slot_q] <= 1'b1;
                default: ;
            endcase
        end
    end

    assign status     = status_q;
    assign slot       = slot_q;
    assign cam_query  = user_q;
    assign cam_waddr  = slot_q;
    assign cam_wdata  = user_q;
    assign cam_wlen   = user_len;
    assign hash_waddr = slot_q;
    assign hash_wdata = h;

endmodule

// File: tb/tb_cred_enroller.sv
module tb_cred_enroller;
    localparam int NS = 8;
    localparam int AW = 3;
    localparam int HW = 32;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [63:0]   username, password;
    logic          busy, done;
    logic [1:0]    status;
    logic [AW-1:0] slot;
    logic [63:0]   cam_query;
    logic          cam_hit;
    logic          cam_we, hash_we;
    logic [AW-1:0] cam_waddr, hash_waddr;
    logic [63:0]   cam_wdata;
    logic [3:0]    cam_wlen;
    logic [HW-1:0] hash_wdata;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    cred_enroller #(.NUM_SLOTS(NS), .ADDR_W(AW), .HASH_W(HW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .username(username), .password(password),
        .busy(busy), .done(done), .status(status), .slot(slot),
        .cam_query(cam_query), .cam_hit(cam_hit),
        .cam_we(cam_we), .cam_waddr(cam_waddr), .cam_wdata(cam_wdata), .cam_wlen(cam_wlen),
        .hash_we(hash_we), .hash_waddr(hash_waddr), .hash_wdata(hash_wdata)
    );

    // ---------------- string helpers / reference functions ----------------
    function automatic int slen(input logic [63:0] s);
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            if (s[8*i +: 8] == 8'h00) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [63:0] trim(input logic [63:0] s, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = s[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] fnv(input logic [63:0] p, input int n);
        logic [31:0] hv = 32'h811C9DC5;
        for (int i = 0; i < n; i++) hv = (hv ^ {24'b0, p[8*i +: 8]}) * 32'h01000193;
        return hv;
    endfunction

    function automatic logic [63:0] s2w(input string s);
        logic [63:0] w = '0;
        for (int i = 0; i < s.len() && i < 8; i++) w[8*i +: 8] = s[i];
        return w;
    endfunction

    function automatic logic [63:0] rnd_str();
        logic [63:0] w;
        int n;
        w = {$urandom, $urandom};
        n = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 8));
        for (int i = 0; i < n; i++) w[8*i +: 8] = 8'($urandom_range(1, 255));
        if (n < 8) w[8*n +: 8] = 8'h00;   // bytes past the terminator stay random
        return w;
    endfunction

    // ---------------- environment CAM (stores what the DUT writes) ----------------
    logic [63:0]   cam_mem [NS];
    logic [NS-1:0] cam_v;
    logic          force_hit;

    always @(posedge clk) begin
        if (reset) cam_v <= '0;
        else if (cam_we) begin
            cam_mem[cam_waddr] <= trim(cam_wdata, int'(cam_wlen));
            cam_v[cam_waddr]   <= 1'b1;
        end
    end

    always_comb begin
        cam_hit = force_hit;
        for (int i = 0; i < NS; i++)
            if (cam_v[i] && cam_mem[i] == trim(cam_query, slen(cam_query))) cam_hit = 1'b1;
    end

    // ---------------- reference model state ----------------
    logic [63:0] m_name [NS];
    bit          m_occ  [NS];
    logic [31:0] last_hash;
    logic [1:0]  last_status;
    int          last_slot, last_lat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; force_hit = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we",   {cam_we, hash_we}, 0);
        chk("rst_status", status, 0);
        chk("rst_slot", slot, 0);
        reset = 1'b0;
        for (int i = 0; i < NS; i++) m_occ[i] = 0;
    endtask

    task automatic enroll(input logic [63:0] u, input logic [63:0] p, input bit fh, input bit spam);
        int ul, pl, est, eslot, elat, we_cyc, we_cnt, hwe_cyc, done_cyc;
        bit dup, full;
        logic [63:0] tu, g_wdata;
        logic [31:0] g_hash;
        logic [3:0]  g_wlen;
        int g_waddr, g_haddr, g_slot;
        logic [1:0] g_status;

        ul = slen(u); pl = slen(p); tu = trim(u, ul);
        dup = 0; full = 1; eslot = -1;
        for (int i = 0; i < NS; i++) begin
            if (m_occ[i] && m_name[i] == tu) dup = 1;
            if (!m_occ[i]) begin
                full = 0;
                if (eslot < 0) eslot = i;
            end
        end
        if (ul == 0 || pl == 0) est = 3;
        else if (dup || fh)     est = 1;
        else if (full)          est = 2;
        else                    est = 0;
        elat = (est == 0) ? pl + 3 : 2;

        @(negedge clk);
        start = 1'b1; username = u; password = p; force_hit = fh;
        @(posedge clk);
        #1 start = 1'b0;

        we_cyc = 0; we_cnt = 0; hwe_cyc = 0; done_cyc = 0;
        g_wdata = '0; g_hash = '0; g_wlen = '0; g_waddr = 0; g_haddr = 0; g_slot = 0; g_status = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) chk("busy_c1", busy, 1);
            if (spam) begin
                start = (n >= 2 && n <= 4);
                username = {$urandom, $urandom};
                password = {$urandom, $urandom};
            end
            if (cam_we) begin
                we_cnt++;
                if (we_cyc == 0) begin
                    we_cyc = n; g_wdata = cam_wdata; g_wlen = cam_wlen; g_waddr = int'(cam_waddr);
                end
            end
            if (hash_we && hwe_cyc == 0) begin
                hwe_cyc = n; g_hash = hash_wdata; g_haddr = int'(hash_waddr);
            end
            if (done_cyc != 0 && n == done_cyc + 1) begin
                chk("busy_after_done", busy, 0);
                break;
            end
            if (done && done_cyc == 0) begin
                done_cyc = n; g_status = status; g_slot = int'(slot);
            end
        end
        start = 1'b0; force_hit = 1'b0;

        chk("latency", done_cyc, elat);
        chk("status", g_status, est);
        if (est == 0) begin
            chk("slot", g_slot, eslot);
            chk("we_cycle", we_cyc, pl + 2);
            chk("hwe_cycle", hwe_cyc, pl + 2);
            chk("we_count", we_cnt, 1);
            chk("cam_waddr", g_waddr, eslot);
            chk("hash_waddr", g_haddr, eslot);
            chk("cam_wdata", trim(g_wdata, ul), tu);
            chk("cam_wlen", g_wlen, ul);
            chk("hash", g_hash, fnv(p, pl));
            m_occ[eslot] = 1; m_name[eslot] = tu;
        end else begin
            chk("no_we", we_cnt + hwe_cyc, 0);
        end
        last_hash = g_hash; last_status = g_status; last_slot = g_slot; last_lat = done_cyc;
    endtask

    task automatic abort_in_hash();
        int we_seen = 0;
        @(negedge clk);
        start = 1'b1; username = s2w("mallory"); password = s2w("abcdefgh");
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (cam_we || hash_we) we_seen++;
            if (n == 3) reset = 1'b1;           // cycle 3 is inside HASH
            if (n == 4) chk("abort_busy", busy, 0);
            if (n == 6) begin
                reset = 1'b0;
                for (int i = 0; i < NS; i++) m_occ[i] = 0;
            end
        end
        chk("abort_no_we", we_seen, 0);
    endtask

    logic [63:0] pool [12];

    initial begin
        reset = 1'b1; start = 1'b0; force_hit = 1'b0;
        username = '0; password = '0;
        last_hash = '0; last_status = '0; last_slot = 0; last_lat = 0;

        // 1: basic enroll
        do_reset();
        enroll(s2w("bob"), s2w("a"), 0, 0);
        chk("bob_hash_const", last_hash, 32'hE40C292C);
        chk("bob_slot", last_slot, 0);

        // 2: fill the table, then one more is FULL
        for (int i = 1; i < 8; i++) enroll(s2w($sformatf("user%0d", i)), s2w("pw"), 0, 0);
        enroll(s2w("ninth"), s2w("pw"), 0, 0);
        chk("full_status", last_status, 2);
        chk("full_lat", last_lat, 2);

        // 3: duplicates, natural and forced, leave occupancy alone
        do_reset();
        enroll(s2w("bob"), s2w("x"), 0, 0);
        enroll(s2w("bob"), s2w("y"), 0, 0);
        chk("dup_status", last_status, 1);
        enroll(s2w("eve"), s2w("y"), 1, 0);
        enroll(s2w("carl"), s2w("z"), 0, 0);
        chk("after_dup_slot", last_slot, 1);

        // 4: empty strings
        enroll(s2w("dave"), 64'h0, 0, 0);
        enroll(64'h0, s2w("pw"), 0, 0);
        enroll(64'h0, 64'h0, 0, 0);
        chk("bad_status", last_status, 3);

        // 5: 8-byte password with start pulses while busy
        enroll(s2w("frank"), s2w("abcdefgh"), 0, 1);
        chk("pw8_latency", last_lat, 11);

        // 6: reset in HASH aborts; next enroll starts at slot 0
        abort_in_hash();
        enroll(s2w("gina"), s2w("pw"), 0, 0);
        chk("post_abort_slot", last_slot, 0);

        // randomized rounds
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) pool[i] = rnd_str();
            do_reset();
            for (int k = 0; k < 25; k++) begin
                logic [63:0] pw;
                pw = rnd_str();
                enroll(pool[$urandom_range(0, 11)], pw, ($urandom_range(0, 7) == 0),
                       (slen(pw) >= 4) && $urandom_range(0, 1) == 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
